// File: rtl/device_fsm_pkg.sv
// Shared types and constants for the push-button FIFO control FSM.
// State codes are fixed because they are shown directly on the board display.
package device_fsm_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = $clog2(FIFO_DEPTH);
  localparam int PTR_W      = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ      = 3'd2,
    S_WAIT_REL  = 3'd3,
    S_FULL_ERR  = 3'd4,
    S_EMPTY_ERR = 3'd5
  } state_e;

  localparam logic [2:0] ST_IDLE      = S_IDLE;
  localparam logic [2:0] ST_WRITE     = S_WRITE;
  localparam logic [2:0] ST_READ      = S_READ;
  localparam logic [2:0] ST_WAIT_REL  = S_WAIT_REL;
  localparam logic [2:0] ST_FULL_ERR  = S_FULL_ERR;
  localparam logic [2:0] ST_EMPTY_ERR = S_EMPTY_ERR;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces an active-low push-button and emits a one-cycle
// press pulse on each accepted 1->0 transition of the debounced level.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_press,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // r_armed stays low until a genuinely released level has been sampled after
  // reset, so a button held through reset cannot masquerade as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_cnt      <= '0;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= i_button;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_fill     <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_sync2) begin
        r_armed <= 1'b1;
      end
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == CNT_DONE) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_press  = r_armed & r_stable_d & ~r_stable;
  assign o_stable = r_stable;

endmodule

// File: rtl/device_fsm.sv
// Control FSM for an 8-entry FIFO: each debounced button press performs one
// write (mode=1) or one read (mode=0) and advances the matching pointer.
module device_fsm
  import device_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             mode,
  output logic [PTR_W-1:0] Read_Ptr,
  output logic [PTR_W-1:0] Write_Ptr,
  output logic [2:0]       out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  logic             r_mode_sync1;
  logic             r_mode_sync2;
  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic             w_press;
  logic             w_stable;
  logic             w_full;
  logic             w_empty;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk     (clk),
    .reset   (reset),
    .i_button(button),
    .o_press (w_press),
    .o_stable(w_stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_sync1 <= 1'b0;
      r_mode_sync2 <= 1'b0;
    end else begin
      r_mode_sync1 <= mode;
      r_mode_sync2 <= r_mode_sync1;
    end
  end

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[ADDR_W-1:0] == r_wr_ptr[ADDR_W-1:0]) &&
                   (r_rd_ptr[PTR_W-1] != r_wr_ptr[PTR_W-1]);

  // Mode only matters on the press cycle in IDLE; every other state ignores it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          if (r_mode_sync2) begin
            w_state_next = w_full ? ST_FULL_ERR : ST_WRITE;
          end else begin
            w_state_next = w_empty ? ST_EMPTY_ERR : ST_READ;
          end
        end
      end
      ST_WRITE:     w_state_next = ST_WAIT_REL;
      ST_READ:      w_state_next = ST_WAIT_REL;
      ST_WAIT_REL,
      ST_FULL_ERR,
      ST_EMPTY_ERR: begin
        if (w_stable) begin
          w_state_next = ST_IDLE;
        end
      end
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_WRITE) begin
        r_wr_ptr <= ptrInc(r_wr_ptr);
      end
      if (r_state == ST_READ) begin
        r_rd_ptr <= ptrInc(r_rd_ptr);
      end
    end
  end

  assign out        = r_state;
  assign Read_Ptr   = r_rd_ptr;
  assign Write_Ptr  = r_wr_ptr;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;

endmodule

// File: tb/tb_device_fsm.sv
// Directed bench for device_fsm: a table of single-press operations filling and
// draining the FIFO, plus hand sequences for latency, debounce, wrap and reset.
module tb_device_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       button;
  logic       mode;
  logic [3:0] readPtr;
  logic [3:0] writePtr;
  logic [2:0] stateOut;
  logic       fifoFull;
  logic       fifoEmpty;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic       mode;
    int         hold;
    logic [2:0] expHeld;
    logic [3:0] expWptr;
    logic [3:0] expRptr;
    logic       expFull;
    logic       expEmpty;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  device_fsm #(
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .mode      (mode),
    .Read_Ptr  (readPtr),
    .Write_Ptr (writePtr),
    .out       (stateOut),
    .fifo_full (fifoFull),
    .fifo_empty(fifoEmpty)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Flags are derived from the occupancy count rather than the pointer bits.
  task automatic checkFlags(input string tag, input logic [3:0] w, input logic [3:0] r);
    logic [3:0] count;
    count = w - r;
    checkOutput({tag, " Write_Ptr"}, writePtr, w);
    checkOutput({tag, " Read_Ptr"}, readPtr, r);
    checkOutput({tag, " fifo_full"}, fifoFull, count == 4'd8);
    checkOutput({tag, " fifo_empty"}, fifoEmpty, count == 4'd0);
  endtask

  task automatic pressOp(input logic m, input int hold, output logic [2:0] heldOut);
    mode   = m;
    button = 1'b0;
    repeat (hold) @(negedge clk);
    heldOut = stateOut;
    button  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [2:0] held;
    pressOp(v.mode, v.hold, held);
    checkOutput($sformatf("vec%0d held state", idx), held, v.expHeld);
    checkOutput($sformatf("vec%0d idle after release", idx), stateOut, 3'd0);
    checkOutput($sformatf("vec%0d Write_Ptr", idx), writePtr, v.expWptr);
    checkOutput($sformatf("vec%0d Read_Ptr", idx), readPtr, v.expRptr);
    checkOutput($sformatf("vec%0d fifo_full", idx), fifoFull, v.expFull);
    checkOutput($sformatf("vec%0d fifo_empty", idx), fifoEmpty, v.expEmpty);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] held;
    logic [3:0] mW;
    logic [3:0] mR;

    vecs[0]  = '{1'b1,  8, 3'd3, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1,  9, 3'd3, 4'd2, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10, 3'd3, 4'd3, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1,  8, 3'd3, 4'd4, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 12, 3'd3, 4'd5, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1,  8, 3'd3, 4'd6, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1,  8, 3'd3, 4'd7, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1,  8, 3'd3, 4'd8, 4'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 10, 3'd4, 4'd8, 4'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0,  8, 3'd3, 4'd8, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0,  9, 3'd3, 4'd8, 4'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0,  8, 3'd3, 4'd8, 4'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 15, 3'd3, 4'd8, 4'd4, 1'b0, 1'b0};
    vecs[13] = '{1'b0,  8, 3'd3, 4'd8, 4'd5, 1'b0, 1'b0};
    vecs[14] = '{1'b0,  8, 3'd3, 4'd8, 4'd6, 1'b0, 1'b0};
    vecs[15] = '{1'b0,  8, 3'd3, 4'd8, 4'd7, 1'b0, 1'b0};
    vecs[16] = '{1'b0,  8, 3'd3, 4'd8, 4'd8, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 10, 3'd5, 4'd8, 4'd8, 1'b0, 1'b1};

    reset  = 1'b1;
    button = 1'b1;
    mode   = 1'b0;
    @(negedge clk);
    checkOutput("reset out", stateOut, 3'd0);
    checkFlags("reset", 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Press latency: WRITE on the 5th edge, pointer moves on the 6th.
    mode   = 1'b1;
    button = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("latency edge4 out", stateOut, 3'd0);
    @(negedge clk);
    checkOutput("latency edge5 out", stateOut, 3'd1);
    checkOutput("latency edge5 Write_Ptr", writePtr, 4'd0);
    @(negedge clk);
    checkOutput("latency edge6 out", stateOut, 3'd3);
    checkOutput("latency edge6 Write_Ptr", writePtr, 4'd1);
    button = 1'b1;
    repeat (8) @(negedge clk);

    doReset();
    checkOutput("second reset out", stateOut, 3'd0);
    checkFlags("second reset", 4'd0, 4'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i], i);
    end

    mW = 4'd8;
    mR = 4'd8;

    pressOp(1'b1, 20, held);
    mW = mW + 4'd1;
    checkOutput("long hold held state", held, 3'd3);
    checkFlags("long hold", mW, mR);

    button = 1'b0;
    @(negedge clk);
    button = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("glitch out", stateOut, 3'd0);
    checkFlags("glitch", mW, mR);

    // A mode flip while waiting for release must not start a second operation.
    mode   = 1'b0;
    button = 1'b0;
    repeat (8) @(negedge clk);
    mode = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("mode toggle held state", stateOut, 3'd3);
    button = 1'b1;
    repeat (8) @(negedge clk);
    mR = mR + 4'd1;
    checkOutput("mode toggle out", stateOut, 3'd0);
    checkFlags("mode toggle", mW, mR);

    for (int i = 0; i < 16; i++) begin
      pressOp(1'b1, 8, held);
      mW = mW + 4'd1;
      checkFlags($sformatf("pair%0d write", i), mW, mR);
      pressOp(1'b0, 8, held);
      mR = mR + 4'd1;
      checkFlags($sformatf("pair%0d read", i), mW, mR);
      if (i == 6) begin
        checkOutput("wrap Write_Ptr zero", writePtr, 4'd0);
        checkOutput("wrap Read_Ptr zero", readPtr, 4'd0);
        checkOutput("wrap fifo_empty", fifoEmpty, 1'b1);
      end
    end

    for (int i = 0; i < 8; i++) begin
      pressOp(1'b1, 8, held);
      mW = mW + 4'd1;
    end
    checkFlags("fill across wrap", mW, mR);
    checkOutput("fill across wrap full", fifoFull, 1'b1);

    mode   = 1'b0;
    button = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre-reset held state", stateOut, 3'd3);
    checkOutput("pre-reset Read_Ptr", readPtr, mR + 4'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-op reset out", stateOut, 3'd0);
    checkFlags("mid-op reset", 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("held through reset out", stateOut, 3'd0);
    checkFlags("held through reset", 4'd0, 4'd0);
    button = 1'b1;
    repeat (8) @(negedge clk);
    pressOp(1'b1, 8, held);
    checkOutput("post-reset press held state", held, 3'd3);
    checkFlags("post-reset press", 4'd1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/device_fsm.md
Name: device_fsm

Overview:
- Control FSM for an 8-entry FIFO, driven by a user push-button and a mode switch.
- Each debounced button press performs one FIFO operation: a write when mode=1, a read when mode=0.
- Maintains 4-bit read/write pointers (3-bit address plus wrap bit) and drives the full/empty flags and a 3-bit state code.
- Sits between board I/O (button, switch) and the FIFO storage/display logic.

Parameters:
DEBOUNCE_CYCLES, 2, number of consecutive synchronized samples of a new button level required before it is accepted (must be ≥1).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
button  input  1  push-button, active-low (1 = released, 0 = pressed); asynchronous to clk.
mode  input  1  operation select; 1 = write, 0 = read; asynchronous to clk.
Read_Ptr  output  4  read pointer; [2:0] is the address, [3] is the wrap bit.
Write_Ptr  output  4  write pointer; [2:0] is the address, [3] is the wrap bit.
out  output  3  current FSM state code.
fifo_full  output  1  FIFO holds 8 entries.
fifo_empty  output  1  FIFO holds 0 entries.

Behaviour:
- Reset (synchronous, high): state=IDLE, out=3'd0, both pointers=4'd0, fifo_empty=1, fifo_full=0, button synchronizer/debounce flops=1 (released), mode synchronizer=0, debounce counter=0.
- Input conditioning: button and mode each pass through a 2-flop synchronizer.
- Debounce counter: increments while synchronized button ≠ btn_stable and clears when they are equal. When it reaches DEBOUNCE_CYCLES, btn_stable takes the new level and the counter clears.
- press is a one-cycle pulse on the btn_stable 1→0 transition.
- Release is btn_stable returning to 1.
- Glitches shorter than DEBOUNCE_CYCLES are ignored.
- State codes on out: IDLE=0, WRITE=1, READ=2, WAIT_REL=3, FULL_ERR=4, EMPTY_ERR=5. Codes 6 and 7 are unused; if reached, the FSM returns to IDLE on the next cycle.
- Transitions:
  - IDLE, press, mode_sync=1, not full -> WRITE.
  - IDLE, press, mode_sync=1, full -> FULL_ERR.
  - IDLE, press, mode_sync=0, not empty -> READ.
  - IDLE, press, mode_sync=0, empty -> EMPTY_ERR.
  - WRITE: exactly one cycle; Write_Ptr <= Write_Ptr+1 (mod 16) at that cycle's edge; -> WAIT_REL.
  - READ: exactly one cycle; Read_Ptr <= Read_Ptr+1 (mod 16); -> WAIT_REL.
  - WAIT_REL, FULL_ERR, EMPTY_ERR: hold until btn_stable=1, then -> IDLE. Pointers are unchanged in these states.
- Flags (combinational from the registered pointers):
  - fifo_empty = (Read_Ptr == Write_Ptr).
  - fifo_full = (Read_Ptr[2:0] == Write_Ptr[2:0]) && (Read_Ptr[3] != Write_Ptr[3]).
- Exactly one operation per press, however long the button is held.
- Mode is sampled only in IDLE on the press cycle; mode changes at any other time have no effect.
- Latency: from the first rising edge sampling button=0, state=WRITE/READ appears on out after 2 + DEBOUNCE_CYCLES + 1 edges (5 by default). The pointer update is visible one edge later.
- Wrap: pointers roll from 4'hF to 4'h0; flag logic stays correct across the wrap.
- Reset mid-operation (any state) forces IDLE and clears both pointers; a button held through reset requires a release before the next press is recognized.
- No read and write can occur in the same cycle.

Decomposition:
- Package device_fsm_pkg: state enum (3-bit, encodings above), FIFO_DEPTH=8, PTR_W=4.
- One sub-module, button_conditioner: synchronizer, debounce counter and press/release detection, parameterized by DEBOUNCE_CYCLES.
- The mode synchronizer lives in the top module.

Test Plan:
- Reset -> out=0, Read_Ptr=Write_Ptr=0, fifo_empty=1, fifo_full=0.
- mode=1, 8 presses each held ≥8 cycles -> Write_Ptr=4'b1000, fifo_full=1, fifo_empty=0, out returns to 0 after each release.
- 9th write press -> out=4 while held, Write_Ptr remains 4'b1000, back to 0 on release.
- mode=0, 8 presses -> Read_Ptr=4'b1000, fifo_empty=1. A further press -> out=5, Read_Ptr unchanged.
- Button held low 20 cycles -> single increment. A 1-cycle low glitch -> no state change. Mode toggled during WAIT_REL -> no effect.
- 16 write/read pairs -> both pointers wrap to 0, fifo_empty=1. Reset asserted during WAIT_REL with pointers nonzero -> pointers 0 and out=0 on the next edge.
